// File: rtl/ft6206_defines.sv
// ft6206_defines: FT6206 touch controller report type
package ft6206_defines;
    localparam int FT6206_CW = 10;
    typedef struct packed {
        logic                 valid;
        logic [FT6206_CW-1:0] x;
        logic [FT6206_CW-1:0] y;
    } touch_t;
endpackage

// File: rtl/ili9341_defines.sv
// ili9341_defines: ILI9341 panel geometry and pixel colour type shared by display blocks
package ili9341_defines;
    localparam int ILI9341_WIDTH  = 240;
    localparam int ILI9341_HEIGHT = 320;
    typedef logic [15:0] ILI9341_color_t;
endpackage

// File: rtl/vram_sketch_writer_xy_to_addr.sv
// xy_to_addr: signed pixel coordinate to linear VRAM address plus on-screen flag
module xy_to_addr #(
    parameter int WIDTH  = 240,
    parameter int HEIGHT = 320,
    parameter int AW     = 17,
    parameter int CW     = 11
) (
    input  logic signed [CW-1:0] x,
    input  logic signed [CW-1:0] y,
    output logic [AW-1:0]        addr,
    output logic                 in_range
);
    localparam logic signed [CW-1:0] WS = CW'(WIDTH);
    localparam logic signed [CW-1:0] HS = CW'(HEIGHT);
    logic [AW-1:0] xa, ya;
    assign xa = AW'(x);
    assign ya = AW'(y);
    assign in_range = !x[CW-1] && !y[CW-1] && (x < WS) && (y < HS);
    if (WIDTH == 240) begin : g_shift
        assign addr = (ya << 8) - (ya << 4) + xa;
    end else begin : g_mul
        assign addr = ya * AW'(WIDTH) + xa;
    end
endmodule

// File: rtl/vram_sketch_writer.sv
// vram_sketch_writer: clears VRAM, then stamps a square brush at each new touch point
module vram_sketch_writer
    import ft6206_defines::*;
    import ili9341_defines::*;
#(
    parameter int             DISPLAY_WIDTH  = ILI9341_WIDTH,
    parameter int             DISPLAY_HEIGHT = ILI9341_HEIGHT,
    parameter int             BRUSH_R        = 1,
    parameter ILI9341_color_t CLEAR_COLOR    = 16'h0000
) (
    input  logic                                             clk,
    input  logic                                             rstb,
    input  logic                                             ena,
    input  logic                                             clear_req,
    input  touch_t                                           touch,
    input  ILI9341_color_t                                   pen_color,
    output logic                                             vram_wr_ena,
    output logic [$clog2(DISPLAY_WIDTH*DISPLAY_HEIGHT)-1:0]  vram_wr_addr,
    output logic [15:0]                                      vram_wr_data,
    output logic                                             busy
);
    localparam int AW = $clog2(DISPLAY_WIDTH*DISPLAY_HEIGHT);
    localparam int CW = $clog2(DISPLAY_WIDTH > DISPLAY_HEIGHT ? DISPLAY_WIDTH : DISPLAY_HEIGHT) + 2;
    localparam logic [AW-1:0]        LAST = AW'(DISPLAY_WIDTH*DISPLAY_HEIGHT-1);
    localparam logic signed [CW-1:0] RS   = CW'(BRUSH_R);

    typedef enum logic [1:0] {S_CLEARING, S_IDLE, S_PAINT} state_t;

    state_t                st;
    logic [AW-1:0]         cnt, pix_addr;
    logic signed [CW-1:0]  px, py, dx, dy;
    ILI9341_color_t        col;
    logic                  last_ok, hit, take;
    logic [FT6206_CW-1:0]  last_x, last_y;

    assign take = ena && touch.valid
                && int'(touch.x) < DISPLAY_WIDTH && int'(touch.y) < DISPLAY_HEIGHT
                && !(last_ok && touch.x == last_x && touch.y == last_y);
    assign busy = st != S_IDLE;

    xy_to_addr #(
        .WIDTH(DISPLAY_WIDTH), .HEIGHT(DISPLAY_HEIGHT), .AW(AW), .CW(CW)
    ) u_xy_to_addr (
        .x(px + dx), .y(py + dy), .addr(pix_addr), .in_range(hit)
    );

    always_ff @(posedge clk) begin
        if (!rstb) begin
            st           <= S_CLEARING;
            cnt          <= '0;
            last_ok      <= 1'b0;
            vram_wr_ena  <= 1'b0;
            vram_wr_addr <= '0;
            vram_wr_data <= CLEAR_COLOR;
        end else if (clear_req) begin
            st          <= S_CLEARING;
            cnt         <= '0;
            last_ok     <= 1'b0;
            vram_wr_ena <= 1'b0;
        end else begin
            case (st)
                S_CLEARING: begin
                    vram_wr_ena  <= 1'b1;
                    vram_wr_addr <= cnt;
                    vram_wr_data <= CLEAR_COLOR;
                    cnt          <= cnt + 1'b1;
                    if (cnt == LAST) st <= S_IDLE;
                end
                S_IDLE: begin
                    vram_wr_ena <= 1'b0;
                    if (take) begin
                        px      <= CW'(touch.x);
                        py      <= CW'(touch.y);
                        col     <= pen_color;
                        dx      <= -RS;
                        dy      <= -RS;
                        last_ok <= 1'b1;
                        last_x  <= touch.x;
                        last_y  <= touch.y;
                        st      <= S_PAINT;
                    end
                end
                S_PAINT: begin
                    // off-screen brush pixels still take their cycle, just without a strobe
                    vram_wr_ena <= hit;
                    if (hit) begin
                        vram_wr_addr <= pix_addr;
                        vram_wr_data <= col;
                    end
                    if (dx == RS) begin
                        dx <= -RS;
                        dy <= dy + CW'(1);
                        if (dy == RS) st <= S_IDLE;
                    end else begin
                        dx <= dx + CW'(1);
                    end
                end
                default: st <= S_CLEARING;
            endcase
        end
    end
endmodule

// File: tb/tb_vram_sketch_writer.sv
// tb_vram_sketch_writer: table, random and corner-case checks against a brush model
module tb_vram_sketch_writer;
    import ft6206_defines::*;

    localparam int W = 240, H = 320, R = 1;
    localparam int SW = 8, SH = 4;

    logic clk = 0, rstb = 0, ena = 0, clear_req = 0, clr_s = 0;
    touch_t touch = '0, touch_s = '0;
    logic [15:0] pen = '0;
    logic wr_e, s_e, busy, s_busy;
    logic [16:0] wr_a;
    logic [4:0] s_a;
    logic [15:0] wr_d, s_d;

    vram_sketch_writer dut (
        .clk(clk), .rstb(rstb), .ena(ena), .clear_req(clear_req), .touch(touch),
        .pen_color(pen), .vram_wr_ena(wr_e), .vram_wr_addr(wr_a), .vram_wr_data(wr_d), .busy(busy)
    );
    vram_sketch_writer #(.DISPLAY_WIDTH(SW), .DISPLAY_HEIGHT(SH)) dut_s (
        .clk(clk), .rstb(rstb), .ena(ena), .clear_req(clr_s), .touch(touch_s),
        .pen_color(pen), .vram_wr_ena(s_e), .vram_wr_addr(s_a), .vram_wr_data(s_d), .busy(s_busy)
    );

    always #5 clk = ~clk;

    typedef struct {int a; int d; int c;} wr_t;
    wr_t wq[$], sq[$];
    int exp_q[$];
    int cyc = 0, bcnt = 0, n_cmp = 0, n_err = 0;
    bit lv = 0;
    int lx, ly;

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) begin
        #1;
        if (wr_e) wq.push_back('{int'(wr_a), int'(wr_d), cyc});
        if (s_e) sq.push_back('{int'(s_a), int'(s_d), cyc});
        if (busy) bcnt++;
    end

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", n, got, exp);
        end
    endtask

    function automatic void brush(input int w, input int h, input int x, input int y);
        exp_q.delete();
        for (int j = y - R; j <= y + R; j++)
            for (int i = x - R; i <= x + R; i++)
                if (i >= 0 && i < w && j >= 0 && j < h) exp_q.push_back(j * w + i);
    endfunction

    task automatic stroke(input int x, input int y, input logic [15:0] p, input bit e, input int hold);
        bit acc;
        @(negedge clk);
        touch.valid = 1; touch.x = 10'(x); touch.y = 10'(y); pen = p; ena = e;
        wq.delete(); bcnt = 0;
        repeat (hold) @(negedge clk);
        touch.valid = 0;
        repeat (12) @(negedge clk);
        acc = e && x < W && y < H && !(lv && x == lx && y == ly);
        if (acc) begin
            brush(W, H, x, y);
            lv = 1; lx = x; ly = y;
        end else exp_q.delete();
        chk("stroke_writes", wq.size(), exp_q.size());
        for (int i = 0; i < wq.size() && i < exp_q.size(); i++) begin
            chk("stroke_addr", wq[i].a, exp_q[i]);
            chk("stroke_data", wq[i].d, p);
        end
        chk("stroke_busy_cycles", bcnt, acc ? (2*R+1)*(2*R+1) : 0);
    endtask

    typedef struct {int x; int y; logic [15:0] p; int n; int first;} vec_t;
    vec_t tbl[6];

    initial begin
        int bad;
        tbl[0] = '{10, 20, 16'hF800, 9, 4569};
        tbl[1] = '{0, 0, 16'h07E0, 4, 0};
        tbl[2] = '{239, 319, 16'h001F, 4, 76558};
        tbl[3] = '{300, 5, 16'h1234, 0, 0};
        tbl[4] = '{5, 320, 16'h4321, 0, 0};
        tbl[5] = '{240, 0, 16'h5A5A, 0, 0};

        repeat (3) @(negedge clk);
        chk("rst_wr_ena", wr_e, 0);
        chk("rst_wr_addr", wr_a, 0);
        chk("rst_wr_data", wr_d, 0);
        chk("rst_busy", busy, 1);
        chk("rst_small_busy", s_busy, 1);
        rstb = 1;
        for (int i = 0; i < 80000 && busy; i++) @(negedge clk);
        chk("clear_done", busy, 0);
        chk("clear_writes", wq.size(), W * H);
        bad = 0;
        foreach (wq[i]) if (wq[i].a != i || wq[i].d != 0) bad++;
        chk("clear_sequence_errors", bad, 0);
        chk("small_clear_writes", sq.size(), SW * SH);
        bad = 0;
        foreach (sq[i]) if (sq[i].a != i || sq[i].d != 0 || sq[i].c != sq[0].c + i) bad++;
        chk("small_clear_sequence_errors", bad, 0);
        chk("small_busy_after_clear", s_busy, 0);

        for (int k = 0; k < 6; k++) begin
            stroke(tbl[k].x, tbl[k].y, tbl[k].p, 1, 1);
            chk("tbl_count", wq.size(), tbl[k].n);
            if (tbl[k].n > 0 && wq.size() > 0) chk("tbl_first_addr", wq[0].a, tbl[k].first);
        end

        stroke(10, 20, 16'hF800, 1, 100);
        chk("hold_single_stroke", wq.size(), 9);
        stroke(300, 5, 16'hF800, 1, 1);

        for (int k = 0; k < 30; k++) begin
            int x, y;
            bit e;
            x = $urandom_range(0, 259);
            y = $urandom_range(0, 339);
            if (lv && $urandom_range(0, 4) == 0) begin x = lx; y = ly; end
            e = $urandom_range(0, 4) != 0;
            stroke(x, y, 16'($urandom), e, 1);
        end

        ena = 1;
        @(negedge clk) clr_s = 1;
        @(negedge clk) clr_s = 0;
        repeat (40) @(negedge clk);
        sq.delete();
        touch_s.valid = 1; touch_s.x = 10'd2; touch_s.y = 10'd1; pen = 16'hABCD;
        @(negedge clk) touch_s.valid = 0;
        @(negedge clk);
        @(negedge clk) clr_s = 1;
        @(negedge clk) clr_s = 0;
        repeat (40) @(negedge clk);
        chk("abort_writes", sq.size(), 2 + SW * SH);
        if (sq.size() == 2 + SW * SH) begin
            chk("abort_stroke0", sq[0].a, 1);
            chk("abort_stroke1", sq[1].a, 2);
            chk("abort_stroke_data", sq[1].d, 16'hABCD);
            bad = 0;
            for (int i = 0; i < SW * SH; i++) if (sq[i+2].a != i || sq[i+2].d != 0) bad++;
            chk("abort_clear_sequence_errors", bad, 0);
        end
        sq.delete();
        touch_s.valid = 1; pen = 16'h5555;
        @(negedge clk) touch_s.valid = 0;
        repeat (12) @(negedge clk);
        brush(SW, SH, 2, 1);
        chk("repaint_writes", sq.size(), exp_q.size());
        for (int i = 0; i < sq.size() && i < exp_q.size(); i++) begin
            chk("repaint_addr", sq[i].a, exp_q[i]);
            chk("repaint_data", sq[i].d, 16'h5555);
        end
        chk("repaint_idle", s_busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
